// File: rtl/bus_pkg.sv
// Shared definitions for the priority bus path: default widths and the
// grant sequencer state encoding.
package bus_pkg;

   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned NUM_REQ_DEF = 4;
   localparam int unsigned SEL_W_DEF   = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/bus_hold_timer.sv
// Counts consecutive ready-less SEND cycles; expired flags the tick that
// completes the HOLD_MAX-th such cycle.
module bus_hold_timer #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int unsigned W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   logic [W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (clear) begin
         wait_cnt <= '0;
      end else if (tick) begin
         wait_cnt <= wait_cnt + W'(1);
      end
   end

   assign expired = tick && (wait_cnt == W'(HOLD_MAX - 1));

endmodule

// File: rtl/bus_grant_sequencer.sv
// Registered grant/handshake stage behind priority_bus_mux: captures the
// winner, presents it on valid/ready, grants it, and inserts a turnaround gap.
module bus_grant_sequencer
   import bus_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
   parameter int unsigned SEL_W    = SEL_W_DEF,
   parameter int unsigned HOLD_MAX = 15,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]  mux_sel,
   input  logic [DATA_W-1:0] mux_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_src,
   output logic [NUM_REQ-1:0] grant,
   output logic              busy,
   output logic              timeout,
   output logic [CNT_W-1:0]  xfer_count
);

   state_t              state, state_n;
   logic                out_valid_n;
   logic [DATA_W-1:0]   out_data_n;
   logic [SEL_W-1:0]    out_src_n;
   logic [NUM_REQ-1:0]  grant_n;
   logic                busy_n;
   logic                timeout_n;
   logic [CNT_W-1:0]    xfer_count_n;
   logic                hold_tick;
   logic                hold_clear;
   logic                hold_expired;

   assign hold_tick  = (state == ST_SEND) && !out_ready;
   assign hold_clear = (state != ST_SEND);

   bus_hold_timer #(
      .HOLD_MAX (HOLD_MAX)
   ) u_hold_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (hold_clear),
      .tick    (hold_tick),
      .expired (hold_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
         xfer_count <= '0;
      end else begin
         state      <= state_n;
         out_valid  <= out_valid_n;
         out_data   <= out_data_n;
         out_src    <= out_src_n;
         grant      <= grant_n;
         busy       <= busy_n;
         timeout    <= timeout_n;
         xfer_count <= xfer_count_n;
      end
   end

   // Next-state logic computes the next value of every output so all ports
   // come straight from flops.
   always_comb begin
      state_n      = state;
      out_valid_n  = out_valid;
      out_data_n   = out_data;
      out_src_n    = out_src;
      grant_n      = grant;
      busy_n       = busy;
      timeout_n    = 1'b0;
      xfer_count_n = xfer_count;
      case (state)
         ST_IDLE: begin
            busy_n = 1'b0;
            if (|req) begin
               state_n     = ST_SEND;
               out_valid_n = 1'b1;
               out_data_n  = mux_data;
               out_src_n   = mux_sel;
               grant_n     = NUM_REQ'(1) << mux_sel;
               busy_n      = 1'b1;
            end
         end
         ST_SEND: begin
            // Accept takes precedence: the timer only ticks while ready is low.
            if (out_ready) begin
               state_n      = ST_RELEASE;
               out_valid_n  = 1'b0;
               grant_n      = '0;
               xfer_count_n = xfer_count + CNT_W'(1);
            end else if (hold_expired) begin
               state_n     = ST_RELEASE;
               out_valid_n = 1'b0;
               grant_n     = '0;
               timeout_n   = 1'b1;
            end
         end
         ST_RELEASE: begin
            state_n     = ST_IDLE;
            out_valid_n = 1'b0;
            grant_n     = '0;
            busy_n      = 1'b0;
         end
         default: begin
            state_n     = ST_IDLE;
            out_valid_n = 1'b0;
            grant_n     = '0;
            busy_n      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Scoreboard bench for bus_grant_sequencer with a behavioural priority mux
// upstream (d0..d3 = A1, B2, C3, D4, lowest index wins).
module tb_bus_grant_sequencer;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [1:0] mux_sel;
   logic [7:0] mux_data;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] out_src;
   logic [3:0] grant;
   logic       busy;
   logic       timeout;
   logic [15:0] xfer_count;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] src;
      logic [3:0] grant;
   } beat_t;

   beat_t sb[$];
   int    checks;
   int    errors;
   int    cyc;
   logic  prev_valid;
   logic  rose;

   bus_grant_sequencer #(
      .DATA_W   (8),
      .NUM_REQ  (4),
      .SEL_W    (2),
      .HOLD_MAX (15),
      .CNT_W    (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .mux_sel    (mux_sel),
      .mux_data   (mux_data),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_src    (out_src),
      .grant      (grant),
      .busy       (busy),
      .timeout    (timeout),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] dval(input int unsigned i);
      case (i)
         0: dval = 8'hA1;
         1: dval = 8'hB2;
         2: dval = 8'hC3;
         default: dval = 8'hD4;
      endcase
   endfunction

   always_comb begin
      mux_sel  = 2'd0;
      mux_data = 8'h00;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) begin
            mux_sel  = 2'(i);
            mux_data = dval(i);
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_beat(input int unsigned idx);
      beat_t b;
      b.data  = dval(idx);
      b.src   = 2'(idx);
      b.grant = 4'(1 << idx);
      sb.push_back(b);
   endtask

   task automatic step();
      beat_t e;
      @(posedge clk);
      #1;
      cyc++;
      rose = out_valid && !prev_valid;
      if (rose) begin
         check_val("sb_pending", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("beat_data", 32'(out_data), 32'(e.data));
            check_val("beat_src", 32'(out_src), 32'(e.src));
            check_val("beat_grant", 32'(grant), 32'(e.grant));
         end
      end
      check_val("grant_iff_valid", 32'(grant != 4'd0), 32'(out_valid));
      prev_valid = out_valid;
   endtask

   task automatic launch(input logic [3:0] r, input int unsigned idx);
      req = r;
      push_beat(idx);
      step();
      check_val("latency_valid", 32'(out_valid), 32'd1);
      check_val("busy_send", 32'(busy), 32'd1);
   endtask

   task automatic check_held(input string tag, input logic [7:0] d, input logic [1:0] s, input logic [3:0] g);
      check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_val({tag, "_data"}, 32'(out_data), 32'(d));
      check_val({tag, "_src"}, 32'(out_src), 32'(s));
      check_val({tag, "_grant"}, 32'(grant), 32'(g));
      check_val({tag, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   int rise_cyc[3];
   int nrise;

   initial begin
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      prev_valid = 1'b0;
      rose       = 1'b0;
      rst        = 1'b1;
      req        = 4'b0000;
      out_ready  = 1'b0;
      #12;
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_grant", 32'(grant), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_count", 32'(xfer_count), 32'd0);
      rst = 1'b0;

      // reset in the middle of a beat
      launch(4'b0001, 0);
      step();
      check_held("pre_rst", 8'hA1, 2'd0, 4'b0001);
      #3;
      rst = 1'b1;
      #1;
      check_val("arst_valid", 32'(out_valid), 32'd0);
      check_val("arst_data", 32'(out_data), 32'd0);
      check_val("arst_src", 32'(out_src), 32'd0);
      check_val("arst_grant", 32'(grant), 32'd0);
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_timeout", 32'(timeout), 32'd0);
      check_val("arst_count", 32'(xfer_count), 32'd0);
      req = 4'b0000;
      step();
      #2;
      rst = 1'b0;
      prev_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("post_rst_valid", 32'(out_valid), 32'd0);
         check_val("post_rst_busy", 32'(busy), 32'd0);
      end

      // single beat accepted immediately
      out_ready = 1'b1;
      launch(4'b0001, 0);
      req = 4'b0000;
      step();
      check_val("t2_valid", 32'(out_valid), 32'd0);
      check_val("t2_count", 32'(xfer_count), 32'd1);
      check_val("t2_busy_rel", 32'(busy), 32'd1);
      step();
      check_val("t2_busy_idle", 32'(busy), 32'd0);

      // three ready-less cycles then accept
      out_ready = 1'b0;
      launch(4'b1110, 1);
      req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         check_held("t3_hold", 8'hB2, 2'd1, 4'b0010);
      end
      out_ready = 1'b1;
      step();
      check_val("t3_valid", 32'(out_valid), 32'd0);
      check_val("t3_count", 32'(xfer_count), 32'd2);
      out_ready = 1'b0;
      step();
      check_val("t3_busy", 32'(busy), 32'd0);

      // timeout after HOLD_MAX ready-less cycles
      launch(4'b1000, 3);
      req = 4'b0000;
      for (int i = 0; i < 14; i++) begin
         step();
         check_held("t4_hold", 8'hD4, 2'd3, 4'b1000);
      end
      step();
      check_val("t4_timeout", 32'(timeout), 32'd1);
      check_val("t4_valid", 32'(out_valid), 32'd0);
      check_val("t4_grant", 32'(grant), 32'd0);
      check_val("t4_data", 32'(out_data), 32'hD4);
      check_val("t4_count", 32'(xfer_count), 32'd2);
      check_val("t4_busy", 32'(busy), 32'd1);
      step();
      check_val("t4_pulse", 32'(timeout), 32'd0);
      check_val("t4_idle", 32'(busy), 32'd0);

      // ready arrives in the final allowed cycle
      launch(4'b0100, 2);
      req = 4'b0000;
      for (int i = 0; i < 14; i++) begin
         step();
         check_held("t5_hold", 8'hC3, 2'd2, 4'b0100);
      end
      out_ready = 1'b1;
      step();
      check_val("t5_timeout", 32'(timeout), 32'd0);
      check_val("t5_valid", 32'(out_valid), 32'd0);
      check_val("t5_count", 32'(xfer_count), 32'd3);
      out_ready = 1'b0;
      step();
      check_val("t5_timeout2", 32'(timeout), 32'd0);

      // request withdrawn during SEND
      launch(4'b0101, 0);
      req = 4'b0000;
      step();
      check_held("t6_hold", 8'hA1, 2'd0, 4'b0001);
      out_ready = 1'b1;
      step();
      check_val("t6_count", 32'(xfer_count), 32'd4);
      step();
      check_val("t6_busy", 32'(busy), 32'd0);

      // back-to-back requests
      req = 4'b0011;
      for (int i = 0; i < 3; i++) push_beat(0);
      nrise = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (rose && nrise < 3) begin
            rise_cyc[nrise] = cyc;
            nrise++;
         end
      end
      req = 4'b0000;
      step();
      check_val("b2b_beats", 32'(nrise), 32'd3);
      check_val("b2b_gap1", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
      check_val("b2b_gap2", 32'(rise_cyc[2] - rise_cyc[1]), 32'd3);
      check_val("b2b_count", 32'(xfer_count), 32'd7);
      check_val("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
